// File: rtl/btn_pkg.sv
`timescale 1ns/1ps
// Shared types and helpers for the push-button debounce bank.
package btn_pkg;

    // Debounce FSM states: stable released, qualifying press, stable pressed, qualifying release.
    typedef enum logic [1:0] {
        UP        = 2'd0,
        WAIT_DOWN = 2'd1,
        DOWN      = 2'd2,
        WAIT_UP   = 2'd3
    } btn_state_e;

    // Width of a counter that must hold values 0..cycles without wrapping.
    function automatic int unsigned cnt_width(input int unsigned cycles);
        int unsigned w;
        w = $clog2(cycles + 1);
        if (w < 1) begin
            w = 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
`timescale 1ns/1ps
// One button channel: 2-flop synchronizer, polarity normalization and
// debounce FSM with registered level, press and release outputs.
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic deb_state,
    output logic deb_press,
    output logic deb_release
);

    localparam int unsigned    CW       = cnt_width(DEBOUNCE_CYCLES);
    localparam logic           INACTIVE = (ACTIVE_LOW != 0);
    localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(1);

    logic          sync_q1;
    logic          sync_q2;
    logic          synced;
    btn_state_e    fsm;
    logic [CW-1:0] cnt;

    // Two-stage synchronizer; reset loads the released pin level so no false press appears.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1 <= INACTIVE;
            sync_q2 <= INACTIVE;
        end else begin
            sync_q1 <= raw;
            sync_q2 <= sync_q1;
        end
    end

    // 1 = pressed regardless of pin polarity.
    assign synced = sync_q2 ^ INACTIVE;

    // Debounce FSM; a new level is accepted only after DEBOUNCE_CYCLES consecutive agreeing samples.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm         <= UP;
            cnt         <= '0;
            deb_state   <= 1'b0;
            deb_press   <= 1'b0;
            deb_release <= 1'b0;
        end else begin
            deb_press   <= 1'b0;
            deb_release <= 1'b0;
            case (fsm)
                UP: begin
                    if (synced) begin
                        fsm <= WAIT_DOWN;
                        cnt <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_DOWN: begin
                    if (!synced) begin
                        fsm <= UP;
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        fsm       <= DOWN;
                        cnt       <= '0;
                        deb_state <= 1'b1;
                        deb_press <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                DOWN: begin
                    if (!synced) begin
                        fsm <= WAIT_UP;
                        cnt <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                WAIT_UP: begin
                    if (synced) begin
                        fsm <= DOWN;
                        cnt <= '0;
                    end else if (cnt == CNT_MAX) begin
                        fsm         <= UP;
                        cnt         <= '0;
                        deb_state   <= 1'b0;
                        deb_release <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: begin
                    fsm <= UP;
                    cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_debounce_bank.sv
`timescale 1ns/1ps
// Bank of independent debounced push-button channels with a shared
// wrapping count of accepted presses.
module button_debounce_bank
    import btn_pkg::*;
#(
    parameter int unsigned NUM_BTNS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 120000,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_BTNS-1:0] btn_raw,
    output logic [NUM_BTNS-1:0] btn_state,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [7:0]          press_total
);

    logic [7:0] press_cnt;

    for (genvar i = 0; i < NUM_BTNS; i++) begin : g_ch
        btn_debounce_ch #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW)
        ) u_ch (
            .clk         (clk),
            .rst         (rst),
            .raw         (btn_raw[i]),
            .deb_state   (btn_state[i]),
            .deb_press   (btn_press[i]),
            .deb_release (btn_release[i])
        );
    end

    // Number of channels strobing a press this cycle.
    always_comb begin
        press_cnt = '0;
        for (int unsigned i = 0; i < NUM_BTNS; i++) begin
            press_cnt = press_cnt + 8'(btn_press[i]);
        end
    end

    // Running press total; wraps naturally at 8 bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            press_total <= '0;
        end else begin
            press_total <= press_total + press_cnt;
        end
    end

endmodule

// File: tb/tb_button_debounce_bank.sv
`timescale 1ns/1ps
// Scoreboard bench for button_debounce_bank (DEBOUNCE_CYCLES=4, ACTIVE_LOW=1).
module tb_button_debounce_bank;

    localparam int unsigned NB  = 4;
    localparam int unsigned DC  = 4;
    // Pin driven after edge c is sampled at c+1, synced by c+2, FSM enters WAIT at c+3,
    // strobe registered at c+3+DC.
    localparam int unsigned LAT = DC + 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NB-1:0] btn_raw = 4'hF;
    logic [NB-1:0] btn_state;
    logic [NB-1:0] btn_press;
    logic [NB-1:0] btn_release;
    logic [7:0]    press_total;

    button_debounce_bank #(
        .NUM_BTNS        (NB),
        .DEBOUNCE_CYCLES (DC),
        .ACTIVE_LOW      (1)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_raw     (btn_raw),
        .btn_state   (btn_state),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .press_total (press_total)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [3:0]  press;
        logic [3:0]  rel;
        logic [3:0]  state;
        logic [7:0]  total;
    } exp_t;

    exp_t        exp_q[$];
    int          checks = 0;
    int          errors = 0;
    logic        mon_en = 1'b0;
    logic        tot_pend = 1'b0;
    logic [7:0]  tot_exp;
    exp_t        mon_e;
    logic [7:0]  exp_total = '0;
    logic [3:0]  exp_state = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        checks++;
        if (act !== want) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, want);
        end
    endtask

    // Monitor: pops an expected record whenever the DUT presents a strobe.
    always @(negedge clk) begin
        if (mon_en) begin
            if (tot_pend) begin
                check("press_total", press_total, tot_exp);
                tot_pend = 1'b0;
            end
            while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
                checks++;
                errors++;
                $display("FAIL missing_strobe: got none by cycle %0d expected press %b release %b at cycle %0d",
                         cyc, exp_q[0].press, exp_q[0].rel, exp_q[0].cyc);
                void'(exp_q.pop_front());
            end
            if ((btn_press | btn_release) !== 4'b0000) begin
                check("press_release_overlap", btn_press & btn_release, 0);
                if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
                    mon_e = exp_q.pop_front();
                    check("btn_press", btn_press, mon_e.press);
                    check("btn_release", btn_release, mon_e.rel);
                    check("btn_state", btn_state, mon_e.state);
                    tot_pend = 1'b1;
                    tot_exp  = mon_e.total;
                end else begin
                    check("unexpected_strobe", {btn_press, btn_release}, 8'h00);
                end
            end
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input logic [3:0] p, input logic [3:0] r);
        exp_t e;
        exp_state  = (exp_state | p) & ~r;
        exp_total  = exp_total + 8'($countones(p));
        e.cyc   = cyc + LAT;
        e.press = p;
        e.rel   = r;
        e.state = exp_state;
        e.total = exp_total;
        exp_q.push_back(e);
    endtask

    task automatic press(input logic [3:0] mask);
        btn_raw = btn_raw & ~mask;
        push(mask, 4'b0000);
        tick(LAT + 1);
    endtask

    task automatic unpress(input logic [3:0] mask);
        btn_raw = btn_raw | mask;
        push(4'b0000, mask);
        tick(LAT + 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        exp_total = '0;
        exp_state = '0;
    endtask

    initial begin
        @(negedge clk);
        // Reset with all pins released (high)
        btn_raw = 4'hF;
        rst = 1'b1;
        tick(3);
        check("reset_state", btn_state, 0);
        check("reset_press", btn_press, 0);
        check("reset_release", btn_release, 0);
        check("reset_total", press_total, 0);
        rst = 1'b0;
        mon_en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick(1);
            check("idle_state", btn_state, 0);
        end

        // Clean press and release on button 0
        press(4'b0001);
        unpress(4'b0001);

        // Bouncing press on button 1: 0,1,0,1 then settles at 0
        btn_raw[1] = 1'b0; tick(1);
        btn_raw[1] = 1'b1; tick(1);
        btn_raw[1] = 1'b0; tick(1);
        btn_raw[1] = 1'b1; tick(1);
        btn_raw[1] = 1'b0;
        push(4'b0010, 4'b0000);
        tick(LAT + 1);
        unpress(4'b0010);

        // Simultaneous press of buttons 0, 2, 3
        press(4'b1101);
        unpress(4'b1101);

        // Wrap: 256 presses bring the total back to 0
        do_reset();
        tick(3);
        for (int i = 0; i < 256; i++) begin
            press(4'b0001);
            unpress(4'b0001);
        end
        check("wrap_256", press_total, 8'd0);
        for (int i = 0; i < 254; i++) begin
            press(4'b0001);
            unpress(4'b0001);
        end
        check("total_254", press_total, 8'd254);
        press(4'b1101);
        check("wrap_254_plus_3", press_total, 8'd1);
        unpress(4'b1101);

        // Reset two cycles into WAIT_DOWN with the pin still held low
        do_reset();
        tick(3);
        btn_raw[0] = 1'b0;
        tick(4);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        check("mid_reset_state", btn_state, 0);
        check("mid_reset_total", press_total, 0);
        exp_total = '0;
        exp_state = '0;
        push(4'b0001, 4'b0000);
        tick(LAT + 1);
        check("post_reset_total", press_total, 8'd1);
        unpress(4'b0001);

        tick(20);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/button_debounce_bank.md
# button_debounce_bank

Input-side counterpart to the board LED drivers. Samples raw mechanical push-button pins, synchronizes them into the clock domain, debounces each one independently, and presents clean levels, single-cycle press/release strobes and a wrapping press counter. It sits directly behind the top-level button pins and feeds user logic, typically LED pattern or counter logic.

## Interface
Parameters:
- NUM_BTNS, 4, number of independent button channels (1..8).
- DEBOUNCE_CYCLES, 120000, consecutive stable cycles required to accept a new level (10 ms at 12 MHz); must be ≥1.
- ACTIVE_LOW, 1, 1 = pressed pin reads 0 (pull-up buttons); 0 = pressed pin reads 1.

Ports:
- clk  in  1  system clock; the only clock.
- rst  in  1  reset, synchronous, active-high.
- btn_raw  in  NUM_BTNS  asynchronous button pins, bit i = button i.
- btn_state  out  NUM_BTNS  debounced level, 1 = pressed (polarity already normalized).
- btn_press  out  NUM_BTNS  one-cycle strobe when btn_state bit rises.
- btn_release  out  NUM_BTNS  one-cycle strobe when btn_state bit falls.
- press_total  out  8  count of accepted presses, all buttons, modulo 256.

## Operation
- Per channel: 2-flop synchronizer → polarity normalize (invert when ACTIVE_LOW=1) → debounce FSM.
- FSM states: UP, WAIT_DOWN, DOWN, WAIT_UP.
  - UP: synced=1 → WAIT_DOWN, counter cleared to 1.
  - WAIT_DOWN: synced=0 → UP (bounce, counter cleared); synced=1 and counter=DEBOUNCE_CYCLES → DOWN, assert press; otherwise increment counter.
  - DOWN / WAIT_UP: mirror of the above, assert release on entry to UP.
- btn_state = 1 in DOWN and WAIT_UP, 0 in UP and WAIT_DOWN.
- Counter width = clog2(DEBOUNCE_CYCLES+1). Counter never exceeds DEBOUNCE_CYCLES and never wraps.
- press_total += popcount(btn_press) each cycle, truncated to 8 bits (255 + 1 → 0; 254 + 3 → 1).
- Channels are fully independent. Simultaneous presses on several channels in one cycle are all counted.
- btn_press and btn_release are never both high on the same bit in the same cycle.

## Timing
- Reset (rst high at a clock edge): synchronizer flops load the inactive level; all FSMs go to UP; counters clear to 0; btn_state, btn_press, btn_release and press_total are all 0 on the following cycle.
- Reset mid-debounce discards any partial count. The first post-reset press is evaluated from scratch.
- Latency: raw pin changes and is held stable from clock edge N. The synced value is visible from edge N+2. btn_state and the strobe update at edge N+2+DEBOUNCE_CYCLES.
- A glitch shorter than DEBOUNCE_CYCLES cycles, measured at the synchronizer output, produces no output change.
- Strobes are registered and last exactly one cycle. press_total reflects a press one cycle after the btn_press strobe.
- No handshake; strobes are not held. Consumers must sample every cycle.

## Structure
- Package btn_pkg: FSM state enum (UP, WAIT_DOWN, DOWN, WAIT_UP); counter-width function.
- Sub-module btn_debounce_ch: one synchronizer + FSM + counter, with outputs state/press/release. The top generates NUM_BTNS instances and owns the press_total adder.

## Test plan
Use DEBOUNCE_CYCLES=4, ACTIVE_LOW=1 unless noted.
- Reset: hold btn_raw=4'b1111 with rst high for 3 cycles → all outputs 0; btn_state stays 0 for ≥10 cycles after release of rst.
- Clean press: btn_raw[0] 1→0 at edge N, held → btn_state[0]=1 and btn_press[0]=1 for exactly one cycle at edge N+6; press_total=1 at N+7. Release mirrors this with a btn_release[0] strobe.
- Bounce: btn_raw[1] toggles 0,1,0,1 at one-cycle intervals, then stays 0 → single press strobe, 6 cycles after the final transition; no spurious strobes.
- Simultaneous: bits 0, 2 and 3 pressed on the same edge → three strobes in the same cycle; press_total increments by 3.
- Wrap: 256 sequential presses on btn 0 → press_total returns to 0. From 254, a 3-button simultaneous press → 1.
- Reset mid-debounce: assert rst 2 cycles into WAIT_DOWN, with the pin still low → no strobe; after rst drops, press accepted DEBOUNCE_CYCLES+2 cycles later; press_total=1.
